// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART frame loader.
// Optional checksum stage is controlled by the LOADER_CHECKSUM_EN macro in uart_frame_loader.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_LEN = 3'd1,
        PAYLOAD = 3'd2,
        CHECK   = 3'd3,
        START   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CSUM = 2'd2,
        ERR_TO   = 2'd3
    } err_t;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_timeout_timer.sv
// Inter-byte idle timer: counts cycles while run is high, restarts on clear,
// and flags expire on the TIMEOUT_CYC-th idle cycle unless a clear arrives in that cycle.
module uart_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear || !run) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    // A byte in the expiry cycle clears the counter and therefore masks the expiry.
    assign expire = run && !clear && (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_frame_loader.sv
// Parses SYNC/LEN/payload[/CHECKSUM] frames from the UART into the network input buffer.
// Define LOADER_CHECKSUM_EN to add the trailing checksum byte and its CHECK state.
module uart_frame_loader
    import uart_loader_pkg::*;
#(
    parameter int         MAX_LEN     = 64,
    parameter int         ADDR_W      = 6,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              nn_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W:0]   frame_len,
    output logic              nn_start,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int LW = ADDR_W + 1;

    // rx_valid/rx_data is a one-cycle strobe with no back-pressure; bytes that
    // cannot be taken (while waiting in START) are dropped and reported.

    state_t        state;
    logic [LW-1:0] len_q;
    logic [LW-1:0] idx;
    logic [7:0]    csum;
    logic          expire;
    logic          timer_run;

    assign timer_run = (state == GET_LEN) || (state == PAYLOAD) || (state == CHECK);
    assign dbg_state = state;

    uart_timeout_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (rx_valid),
        .run    (timer_run),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            len_q     <= '0;
            idx       <= '0;
            csum      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            frame_len <= '0;
            nn_start  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            nn_start  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= GET_LEN;
                        busy  <= 1'b1;
                    end
                end
                GET_LEN: begin
                    if (rx_valid) begin
                        if (rx_data == 8'd0 || int'(rx_data) > MAX_LEN) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end else begin
                            len_q <= LW'(rx_data);
                            idx   <= '0;
                            // Seeding with LEN folds it into the running checksum.
                            csum  <= rx_data;
                            state <= PAYLOAD;
                        end
                    end else if (expire) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_TO;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= idx[ADDR_W-1:0];
                        mem_wdata <= rx_data;
                        idx       <= idx + LW'(1);
                        csum      <= csum + rx_data;
                        if (idx + LW'(1) == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CHECK;
`else
                            state <= START;
`endif
                        end
                    end else if (expire) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_TO;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == csum) begin
                            state <= START;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CSUM;
                            state     <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else if (expire) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_TO;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
`endif
                START: begin
                    // An overrun byte is reported but does not block the pending start.
                    if (rx_valid) begin
                        frame_err <= 1'b1;
                        err_code  <= ERR_TO;
                    end
                    if (!nn_busy) begin
                        nn_start  <= 1'b1;
                        frame_len <= len_q;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
